// File: rtl/controlador_permutacao.sv
// Shuffle sequencer: draws permutations from the index generator with retry
// and identity fallback, then streams the four 2-bit memory indices out.
module controlador_permutacao #(
    parameter int MAX_TRIES = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] rnd_in,
    output logic [15:0] gen_entrada,
    input  logic [7:0]  gen_perm,
    input  logic        gen_ready,
    output logic [1:0]  idx_out,
    output logic [1:0]  idx_slot,
    output logic        idx_valid,
    input  logic        idx_ready,
    output logic        busy,
    output logic        done,
    output logic        fallback,
    output logic [3:0]  tries
);

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        CHECK,
        ISSUE,
        DONE
    } state_t;

    localparam logic [3:0] MAX_T = 4'(MAX_TRIES);
    localparam logic [7:0] IDENT = 8'b00_01_10_11;

    state_t     state;
    state_t     next_state;
    logic [7:0] perm_q;
    logic [1:0] k;
    logic [3:0] tries_q;
    logic       fallback_q;
    logic       last_try;

    assign gen_entrada = rnd_in;
    assign last_try    = (tries_q + 4'd1) == MAX_T;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    next_state = SAMPLE;
                end
            end
            SAMPLE: next_state = CHECK;
            CHECK: begin
                if (gen_ready || last_try) begin
                    next_state = ISSUE;
                end else begin
                    next_state = SAMPLE;
                end
            end
            ISSUE: begin
                if (idx_ready && k == 2'd3) begin
                    next_state = DONE;
                end
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath registers; perm_q is only written in CHECK so it stays frozen during ISSUE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perm_q     <= 8'd0;
            k          <= 2'd0;
            tries_q    <= 4'd0;
            fallback_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        tries_q    <= 4'd0;
                        fallback_q <= 1'b0;
                    end
                    k <= 2'd0;
                end
                CHECK: begin
                    tries_q <= tries_q + 4'd1;
                    if (gen_ready) begin
                        perm_q <= gen_perm;
                    end else if (last_try) begin
                        perm_q     <= IDENT;
                        fallback_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (idx_ready) begin
                        k <= k + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        idx_valid = 1'b0;
        idx_slot  = 2'd0;
        idx_out   = 2'd0;
        busy      = (state != IDLE);
        done      = (state == DONE);
        fallback  = fallback_q;
        tries     = tries_q;
        if (state == ISSUE) begin
            idx_valid = 1'b1;
            idx_slot  = k;
            unique case (k)
                2'd0: idx_out = perm_q[7:6];
                2'd1: idx_out = perm_q[5:4];
                2'd2: idx_out = perm_q[3:2];
                2'd3: idx_out = perm_q[1:0];
                default: idx_out = 2'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_permutacao.sv
// Directed bench for controlador_permutacao: accept, retry, fallback,
// backpressure, back-to-back start and asynchronous reset.
module tb_controlador_permutacao;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] rnd_in;
    logic [15:0] gen_entrada;
    logic [7:0]  gen_perm;
    logic        gen_ready;
    logic [1:0]  idx_out;
    logic [1:0]  idx_slot;
    logic        idx_valid;
    logic        idx_ready;
    logic        busy;
    logic        done;
    logic        fallback;
    logic [3:0]  tries;

    int checks   = 0;
    int failures = 0;

    controlador_permutacao #(.MAX_TRIES(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .rnd_in      (rnd_in),
        .gen_entrada (gen_entrada),
        .gen_perm    (gen_perm),
        .gen_ready   (gen_ready),
        .idx_out     (idx_out),
        .idx_slot    (idx_slot),
        .idx_valid   (idx_valid),
        .idx_ready   (idx_ready),
        .busy        (busy),
        .done        (done),
        .fallback    (fallback),
        .tries       (tries)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    // Pulse start across one rising edge; returns in cycle 1 (SAMPLE).
    task automatic go();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            cyc();
        end
        chk(tag, 32'(busy), 0);
    endtask

    task automatic chk_idx(input string tag, input logic [1:0] slot,
                           input logic [1:0] val);
        chk({tag, "_valid"}, 32'(idx_valid), 1);
        chk({tag, "_slot"}, 32'(idx_slot), 32'(slot));
        chk({tag, "_idx"}, 32'(idx_out), 32'(val));
        chk({tag, "_nodone"}, 32'(done), 0);
    endtask

    task automatic run_ideal(input string tag, input logic [7:0] p,
                             input logic [1:0] e0, input logic [1:0] e1,
                             input logic [1:0] e2, input logic [1:0] e3);
        logic [1:0] e [4];
        e = '{e0, e1, e2, e3};
        gen_perm  = p;
        gen_ready = 1'b1;
        idx_ready = 1'b1;
        go();
        chk({tag, "_c1_busy"}, 32'(busy), 1);
        chk({tag, "_c1_valid"}, 32'(idx_valid), 0);
        cyc();
        chk({tag, "_c2_valid"}, 32'(idx_valid), 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk_idx({tag, "_s"}, 2'(i), e[i]);
        end
        cyc();
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_done_valid"}, 32'(idx_valid), 0);
        chk({tag, "_tries"}, 32'(tries), 1);
        chk({tag, "_fb"}, 32'(fallback), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b1;
        rnd_in    = 16'hA5C3;
        gen_perm  = 8'h00;
        gen_ready = 1'b0;
        idx_ready = 1'b1;

        // Reset held with start high
        repeat (3) cyc();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_valid", 32'(idx_valid), 0);
        chk("rst_idx", 32'(idx_out), 0);
        chk("rst_slot", 32'(idx_slot), 0);
        chk("rst_fb", 32'(fallback), 0);
        chk("rst_tries", 32'(tries), 0);
        chk("rst_entrada", 32'(gen_entrada), 32'h0000A5C3);
        reset = 1'b0;
        cyc();
        chk("rel_sample_busy", 32'(busy), 1);
        chk("rel_valid", 32'(idx_valid), 0);
        start     = 1'b0;
        gen_ready = 1'b1;
        wait_idle("rel_idle");

        // Accept on first draw, then back-to-back start
        run_ideal("acc", 8'b00_11_10_01, 2'd0, 2'd3, 2'd2, 2'd1);
        start = 1'b1;
        cyc();
        chk("b2b_idle", 32'(busy), 0);
        cyc();
        chk("b2b_sample", 32'(busy), 1);
        start = 1'b0;
        wait_idle("b2b_end");

        // Retry: rejected twice, accepted on the third draw
        gen_ready = 1'b0;
        gen_perm  = 8'b10_01_11_00;
        go();
        repeat (5) cyc();
        chk("ret_c6_valid", 32'(idx_valid), 0);
        chk("ret_c6_tries", 32'(tries), 2);
        gen_ready = 1'b1;
        cyc();
        chk_idx("ret_s0", 2'd0, 2'd2);
        chk("ret_tries", 32'(tries), 3);
        cyc();
        chk_idx("ret_s1", 2'd1, 2'd1);
        cyc();
        chk_idx("ret_s2", 2'd2, 2'd3);
        cyc();
        chk_idx("ret_s3", 2'd3, 2'd0);
        cyc();
        chk("ret_done", 32'(done), 1);
        chk("ret_fb", 32'(fallback), 0);
        wait_idle("ret_end");

        // Fallback: every draw rejected
        gen_ready = 1'b0;
        gen_perm  = 8'hB4;
        rnd_in    = 16'h1E2D;
        go();
        chk("fb_entrada", 32'(gen_entrada), 32'h00001E2D);
        repeat (15) cyc();
        chk("fb_c16_valid", 32'(idx_valid), 0);
        chk("fb_c16_tries", 32'(tries), 7);
        cyc();
        chk_idx("fb_s0", 2'd0, 2'd0);
        chk("fb_flag", 32'(fallback), 1);
        chk("fb_tries", 32'(tries), 8);
        cyc();
        chk_idx("fb_s1", 2'd1, 2'd1);
        cyc();
        chk_idx("fb_s2", 2'd2, 2'd2);
        cyc();
        chk_idx("fb_s3", 2'd3, 2'd3);
        cyc();
        chk("fb_done", 32'(done), 1);
        chk("fb_done_valid", 32'(idx_valid), 0);
        cyc();
        chk("fb_idle", 32'(busy), 0);
        chk("fb_hold", 32'(fallback), 1);
        chk("fb_hold_tries", 32'(tries), 8);

        // Backpressure at slot 1, generator changes during ISSUE
        gen_ready = 1'b1;
        gen_perm  = 8'b01_10_00_11;
        go();
        chk("bp_fb_clr", 32'(fallback), 0);
        cyc();
        cyc();
        chk_idx("bp_s0", 2'd0, 2'd1);
        cyc();
        chk_idx("bp_s1", 2'd1, 2'd2);
        idx_ready = 1'b0;
        gen_perm  = 8'hFF;
        cyc();
        chk_idx("bp_hold1", 2'd1, 2'd2);
        cyc();
        chk_idx("bp_hold2", 2'd1, 2'd2);
        cyc();
        chk_idx("bp_hold3", 2'd1, 2'd2);
        idx_ready = 1'b1;
        cyc();
        chk_idx("bp_s2", 2'd2, 2'd0);
        cyc();
        chk_idx("bp_s3", 2'd3, 2'd3);
        cyc();
        chk("bp_done", 32'(done), 1);
        wait_idle("bp_end");

        // Asynchronous reset during ISSUE slot 2
        gen_perm = 8'b11_10_01_00;
        go();
        repeat (4) cyc();
        chk_idx("ar_s2", 2'd2, 2'd1);
        reset = 1'b1;
        #1;
        chk("ar_valid", 32'(idx_valid), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_done", 32'(done), 0);
        chk("ar_tries", 32'(tries), 0);
        cyc();
        chk("ar_done_hold", 32'(done), 0);
        reset = 1'b0;
        cyc();
        chk("ar_rel_idle", 32'(busy), 0);
        chk("ar_rel_done", 32'(done), 0);
        run_ideal("post", 8'b00_11_10_01, 2'd0, 2'd3, 2'd2, 2'd1);
        wait_idle("post_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
